// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS main control FSM driving the ALU and datapath selects
module mc_control_fsm #(
  parameter int OPW      = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPW-1:0]      opcode,
  input  logic [OPW-1:0]      funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                imm_zext,
  output logic [1:0]          pc_source,
  output logic                pc_write,
  output logic                ior_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                instr_done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_RWB, S_EXEC_I, S_IWB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_AND  = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_OR   = ALUCTL_W'(3'b011);
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = ALUCTL_W'(3'b100);
  localparam logic [ALUCTL_W-1:0] ALU_NOR  = ALUCTL_W'(3'b101);
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = ALUCTL_W'(3'b111);

  state_t state, next_state;

  logic                r_ok;
  logic [ALUCTL_W-1:0] r_ctl;
  logic                i_ok;
  logic                i_zext;
  logic [ALUCTL_W-1:0] i_ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // R-type funct decode, shared by DECODE (legality) and EXEC_R (operation)
  always_comb begin
    r_ok  = 1'b1;
    r_ctl = ALU_ADD;
    case (funct)
      6'b100000, 6'b100001: r_ctl = ALU_ADD;
      6'b100010, 6'b100011: r_ctl = ALU_SUB;
      6'b100100:            r_ctl = ALU_AND;
      6'b100101:            r_ctl = ALU_OR;
      6'b100110:            r_ctl = ALU_XOR;
      6'b100111:            r_ctl = ALU_NOR;
      6'b101010:            r_ctl = ALU_SLT;
      6'b101011:            r_ctl = ALU_SLTU;
      default:              r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_ok   = 1'b1;
    i_zext = 1'b0;
    i_ctl  = ALU_ADD;
    case (opcode)
      6'b001000, 6'b001001: i_ctl = ALU_ADD;
      6'b001010:            i_ctl = ALU_SLT;
      6'b001011:            i_ctl = ALU_SLTU;
      6'b001100: begin      i_ctl = ALU_AND; i_zext = 1'b1; end
      6'b001101: begin      i_ctl = ALU_OR;  i_zext = 1'b1; end
      6'b001110: begin      i_ctl = ALU_XOR; i_zext = 1'b1; end
      default:              i_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    alu_ctl    = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_source  = 2'b00;
    pc_write   = 1'b0;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    // Outputs stay quiet for the whole time reset is held, not just until the next edge
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) next_state = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          if (opcode == OP_RTYPE && r_ok)              next_state = S_EXEC_R;
          else if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEMADR;
          else if (opcode == OP_BEQ || opcode == OP_BNE) next_state = S_BRANCH;
          else if (opcode == OP_J)                     next_state = S_JUMP;
          else if (i_ok)                               next_state = S_EXEC_I;
          else begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          ior_d    = 1'b1;
          if (mem_ready) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          ior_d      = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) next_state = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a  = 1'b1;
          alu_ctl    = r_ctl;
          next_state = S_RWB;
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          alu_ctl    = i_ctl;
          imm_zext   = i_zext;
          next_state = S_IWB;
        end
        S_IWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_ctl    = ALU_SUB;
          pc_source  = 2'b01;
          pc_write   = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized bench for mc_control_fsm against an instruction-level model
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [2:0] alu_ctl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [1:0] pc_source;
  logic       pc_write, ior_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;

  always #5 clk = ~clk;

  mc_control_fsm #(.OPW(6), .ALUCTL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_ctl(alu_ctl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_source(pc_source),
    .pc_write(pc_write), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_source;
    logic       pc_write, ior_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;
  } outs_t;

  outs_t got, exp_v;
  assign got = {alu_ctl, alu_src_a, alu_src_b, imm_zext, pc_source, pc_write, ior_d,
                mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                instr_done, illegal};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cur_ph = -1;

  // Instruction phases: fetch, decode, address, mem read, load writeback, mem write, execute, writeback, branch, jump
  localparam int P_F = 0, P_D = 1, P_A = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_X = 6, P_WB = 7, P_BR = 8, P_J = 9;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5, C_J = 6, C_ILL = 7;

  logic [5:0] rfn  [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
  logic [2:0] rctl [10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [5:0] iop  [7]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};
  logic [2:0] ictl [7]  = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4};
  logic       izx  [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      for (int i = 0; i < 10; i++) if (fn == rfn[i]) return C_R;
      return C_ILL;
    end
    for (int i = 0; i < 7; i++) if (op == iop[i]) return C_I;
    case (op)
      6'h23:   return C_LW;
      6'h2b:   return C_SW;
      6'h04:   return C_BEQ;
      6'h05:   return C_BNE;
      6'h02:   return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int base_latency(input int cls);
    case (cls)
      C_LW:                return 5;
      C_BEQ, C_BNE, C_J:   return 3;
      C_ILL:               return 2;
      default:             return 4;
    endcase
  endfunction

  function automatic outs_t model(input int ph, input int cls, input logic [5:0] op,
                                  input logic [5:0] fn, input logic z, input logic mr);
    outs_t o;
    o = '0;
    case (ph)
      P_F:   begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      P_D:   begin
               o.alu_src_b = 2'b11;
               if (cls == C_ILL) begin o.illegal = 1; o.instr_done = 1; end
             end
      P_A:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MR:  begin o.mem_read = 1; o.ior_d = 1; end
      P_MWB: begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      P_MW:  begin o.mem_write = 1; o.ior_d = 1; o.instr_done = mr; end
      P_X:   begin
               o.alu_src_a = 1;
               if (cls == C_R) begin
                 for (int i = 0; i < 10; i++) if (fn == rfn[i]) o.alu_ctl = rctl[i];
               end else begin
                 o.alu_src_b = 2'b10;
                 for (int i = 0; i < 7; i++)
                   if (op == iop[i]) begin o.alu_ctl = ictl[i]; o.imm_zext = izx[i]; end
               end
             end
      P_WB:  begin o.reg_write = 1; o.reg_dst = (cls == C_R); o.instr_done = 1; end
      P_BR:  begin
               o.alu_src_a = 1; o.alu_ctl = 3'b001; o.pc_source = 2'b01; o.instr_done = 1;
               o.pc_write = (cls == C_BEQ) ? z : ~z;
             end
      P_J:   begin o.pc_source = 2'b10; o.pc_write = 1; o.instr_done = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t phase=%0d op=%h fn=%h got=%b exp=%b",
                 $time, cur_ph, opcode, funct, got, exp_v);
      end
      checks++;
      if ((mem_read & mem_write) | (reg_write & pc_write)) begin
        errors++;
        $display("FAIL exclusive t=%0t got rd=%b wr=%b rw=%b pw=%b exp no overlap",
                 $time, mem_read, mem_write, reg_write, pc_write);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, actual, expected);
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs and the expected outputs, then advance one clock
  task automatic cycle(input int ph, input int cls, input logic mr);
    cur_ph    = ph;
    mem_ready = mr;
    exp_v     = model(ph, cls, opcode, funct, zero, mr);
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, output int cycles);
    int cls, nw, waits;
    int ph[$];
    opcode = op;
    funct  = fn;
    zero   = z;
    cls    = classify(op, fn);
    ph     = '{P_F, P_D};
    case (cls)
      C_R, C_I:      begin ph.push_back(P_X); ph.push_back(P_WB); end
      C_LW:          begin ph.push_back(P_A); ph.push_back(P_MR); ph.push_back(P_MWB); end
      C_SW:          begin ph.push_back(P_A); ph.push_back(P_MW); end
      C_BEQ, C_BNE:  ph.push_back(P_BR);
      C_J:           ph.push_back(P_J);
      default:       ;
    endcase
    cycles = 0;
    waits  = 0;
    foreach (ph[k]) begin
      if (ph[k] == P_F || ph[k] == P_MR || ph[k] == P_MW) begin
        nw = (ph[k] == P_F) ? fw : mw;
        if (nw < 0) nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (nw) cycle(ph[k], cls, 1'b0);
        cycle(ph[k], cls, 1'b1);
        cycles += nw + 1;
        waits  += nw;
      end else begin
        cycle(ph[k], cls, 1'($urandom_range(0, 1)));
        cycles++;
      end
    end
    check("latency", cycles, base_latency(cls) + waits);
  endtask

  int   cyc;
  int   sel;
  outs_t m;
  logic [5:0] rop, rfn_v;
  logic [2:0] sweep_exp [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [5:0] sweep_fn  [7] = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    exp_v = '0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(got), 0);
    rst_n = 1'b1;

    m = model(P_F, C_R, 6'h00, 6'h20, 1'b0, 1'b1);
    check("model_fetch_irw", int'({m.ir_write, m.pc_write}), 3);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, cyc);
    check("add_cycles", cyc, 4);

    for (int i = 0; i < 7; i++) begin
      m = model(P_X, C_R, 6'h00, sweep_fn[i], 1'b0, 1'b1);
      check("model_rctl", int'(m.alu_ctl), int'(sweep_exp[i]));
      run_instr(6'h00, sweep_fn[i], 1'b0, 0, 0, cyc);
    end
    run_instr(6'h00, 6'h00, 1'b0, 0, 0, cyc);
    check("illegal_funct_cycles", cyc, 2);

    run_instr(6'h23, 6'h11, 1'b0, 0, 2, cyc);
    check("lw_wait2_cycles", cyc, 7);

    m = model(P_BR, C_BEQ, 6'h04, 6'h00, 1'b1, 1'b1);
    check("model_beq_taken", int'({m.pc_write, m.pc_source}), 5);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, cyc);
    check("beq_cycles", cyc, 3);
    m = model(P_BR, C_BEQ, 6'h04, 6'h00, 1'b0, 1'b1);
    check("model_beq_not_taken", int'(m.pc_write), 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, cyc);
    m = model(P_BR, C_BNE, 6'h05, 6'h00, 1'b0, 1'b1);
    check("model_bne_taken", int'(m.pc_write), 1);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, cyc);

    m = model(P_X, C_I, 6'h0c, 6'h00, 1'b0, 1'b1);
    check("model_andi", int'({m.alu_ctl, m.imm_zext}), 5);
    run_instr(6'h0c, 6'h3f, 1'b0, 0, 0, cyc);
    m = model(P_X, C_I, 6'h0a, 6'h00, 1'b0, 1'b1);
    check("model_slti", int'({m.alu_ctl, m.imm_zext}), 12);
    run_instr(6'h0a, 6'h3f, 1'b0, 0, 0, cyc);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, cyc);
    check("j_cycles", cyc, 3);

    // sw aborted by reset while its memory write is stalled
    opcode = 6'h2b; funct = 6'h00; zero = 1'b0;
    cycle(P_F, C_SW, 1'b1);
    cycle(P_D, C_SW, 1'b1);
    cycle(P_A, C_SW, 1'b1);
    cycle(P_MW, C_SW, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_v = '0;
    #1;
    check("async_reset_outputs", int'(got), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(6'h00, 6'h25, 1'b0, 0, 0, cyc);

    for (int n = 0; n < 150; n++) begin
      sel   = int'($urandom_range(0, 9));
      rfn_v = ($urandom_range(0, 4) == 0) ? 6'($urandom) : rfn[$urandom_range(0, 9)];
      case (sel)
        0, 1, 2: rop = 6'h00;
        3:       rop = 6'h23;
        4:       rop = 6'h2b;
        5:       rop = ($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05;
        6:       rop = 6'h02;
        7, 8:    rop = iop[$urandom_range(0, 6)];
        default: rop = 6'($urandom);
      endcase
      run_instr(rop, rfn_v, 1'($urandom_range(0, 1)), -1, -1, cyc);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS main control unit; the driving end of the ALU interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Issues the 3-bit ALU operation code and operand selects to the ALU, and consumes the ALU zero flag to resolve beq/bne.
- Sits between the external instruction register (opcode/funct), the memory port and the datapath muxes.

Parameters:
OPW, 6, width of opcode and funct fields (fixed by ISA)
ALUCTL_W, 3, width of ALU operation code

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  OPW  IR[31:26]; stable from DECODE until instruction end
funct  input  OPW  IR[5:0]; same stability
zero  input  1  ALU zero flag (1 when ALU result == 0)
mem_ready  input  1  memory handshake; access completes in a cycle where it is 1
alu_ctl  output  ALUCTL_W  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt signed, 111 sltu
alu_src_a  output  1  0=PC, 1=regA
alu_src_b  output  2  00=regB, 01=const 4, 10=ext imm, 11=ext imm<<2
imm_zext  output  1  1=zero-extend immediate (andi/ori/xori), else sign-extend
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
pc_write  output  1  PC load enable
ior_d  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load enable
reg_write  output  1  register file write enable
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
instr_done  output  1  1-cycle pulse in final cycle of each instruction
illegal  output  1  1-cycle pulse on unsupported opcode/funct

Behaviour:
- State register is the only storage. Outputs are combinational from state, opcode, funct, zero and mem_ready.
- Any output not listed for a state is 0.
- Reset:
  - While rst_n=0: state=FETCH and all outputs forced 0.
  - An asynchronous assert mid-instruction aborts it with no further writes.
- FETCH:
  - mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_ctl=000, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_ctl=000 (branch target precompute).
  - Next state: R-type (000000) → EXEC_R; lw 100011 / sw 101011 → MEMADR; beq 000100 / bne 000101 → BRANCH; j 000010 → JUMP; addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110 → EXEC_I.
  - Any other opcode, or an R-type funct not in the list below: illegal=1 and instr_done=1, then → FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctl=000. Next → MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, ior_d=1. Wait on mem_ready, then → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next → FETCH.
- MEMWR: mem_write=1, ior_d=1. instr_done=mem_ready. Wait on mem_ready, then → FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_ctl from funct: add 100000 / addu 100001 → 000, sub 100010 / subu 100011 → 001, and 100100 → 010, or 100101 → 011, xor 100110 → 100, nor 100111 → 101, slt 101010 → 110, sltu 101011 → 111. Next → RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next → FETCH.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10.
  - alu_ctl: addi/addiu → 000, andi → 010, ori → 011, xori → 100, slti → 110, sltiu → 111.
  - imm_zext=1 only for andi/ori/xori.
  - Next → IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next → FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_ctl=001, pc_source=01.
  - pc_write=(beq & zero) | (bne & ~zero).
  - instr_done=1. Next → FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1. Next → FETCH.
- Latency with mem_ready tied to 1:
  - R-type, I-type ALU and sw: 4 cycles.
  - lw: 5 cycles.
  - beq, bne, j: 3 cycles.
  - illegal: 2 cycles.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Never asserted together: mem_read with mem_write; ir_write outside FETCH; reg_write with pc_write.

Test Plan:
- Reset then R-type add: hold rst_n=0 → all outputs 0. Release with mem_ready=1, opcode=000000, funct=100000 → FETCH (ir_write=1, pc_write=1, alu_ctl=000), DECODE, EXEC_R (alu_ctl=000, alu_src_b=00), RWB (reg_write=1, reg_dst=1, instr_done=1).
- funct sweep 100010, 100100, 100101, 100110, 100111, 101010, 101011 → alu_ctl in EXEC_R equals 001, 010, 011, 100, 101, 110, 111 respectively. funct=000000 → illegal=1 in DECODE, back to FETCH.
- lw with mem_ready low for 2 cycles in MEMRD → MEMRD held 3 cycles with mem_read=1, ior_d=1. Total 7 cycles. MEMWB has mem_to_reg=1, reg_write=1.
- beq with zero=1 → pc_write=1, pc_source=01 in BRANCH. Same with zero=0 → pc_write=0. bne with zero=0 → pc_write=1.
- andi (001100) → EXEC_I alu_ctl=010, imm_zext=1. slti (001010) → alu_ctl=110, imm_zext=0. IWB has reg_dst=0.
- Assert rst_n=0 during MEMWR of sw → outputs 0 immediately (asynchronous). After release, first state is FETCH with no mem_write.
